mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM that sequences the shared datapath: instruction/data memory, register file, ALU, the write-register mux and the mem-to-reg mux.
- Decodes Opcode and Funct from the instruction register and drives every mux select and write enable, one state per cycle.
- Waits on a memory-ready handshake for every memory access.
- Sits beside the datapath top level and replaces the open control-unit connections there.

Parameters:
- STATE_W, 4, width of the state register and of the State debug output.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Opcode  input  6  instruction bits 31:26, taken from the instruction register
- Funct  input  6  instruction bits 5:0
- Zero  input  1  ALU zero flag
- Mem_ready  input  1  memory access complete this cycle
- PCEn  output  1  PC load enable; equals PCWrite OR (PCWriteCond AND Zero)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write-register select: 0 = rt, 1 = rd
- MemtoReg  output  1  write-data select: 0 = ALUOut, 1 = MDR
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs
- ALUSrcB  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm shifted left 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = decode Funct
- PCSrc  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- Illegal_op  output  1  one-cycle pulse on an unsupported opcode
- State  output  STATE_W  current state, for debug

Behaviour:
- Opcode map:
  - R-type 6'h00
  - lw 6'h23
  - sw 6'h2B
  - beq 6'h04
  - j 6'h02
  - addi 6'h08
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTEXE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11
- Moore outputs are decoded from the state register. The only exceptions are the Mem_ready gating below and Zero inside PCEn. Any output not listed for a state is 0.
- Reset: Rst_n low forces the state to FETCH immediately, asynchronously.
  - During reset, all outputs are 0 except the FETCH static outputs: MemRead=1, ALUSrcB=01.
  - IRWrite and PCEn stay 0 because Mem_ready is masked while Rst_n is low.
  - A reset during any state, including a pending memory wait, abandons the instruction. No write strobe may be asserted after reset deasserts until the FSM reaches MEMWR or a writeback state again.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=Mem_ready and PCWrite=Mem_ready.
  - Holds while Mem_ready=0; moves to DECODE when Mem_ready=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: lw/sw -> MEMADR, R -> RTEXE, beq -> BRANCH, j -> JUMP, addi -> ADDIEX.
  - Any other opcode: Illegal_op=1 for this cycle, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until Mem_ready=1, then moves to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next state FETCH.
- MEMWR:
  - Drives MemWrite=1, IorD=1, held asserted while waiting.
  - Holds until Mem_ready=1, then moves to FETCH.
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01.
  - Next state FETCH.
- JUMP: PCWrite=1, PCSrc=10. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- Unused encodings (12..15): all outputs 0, next state FETCH.
- Instruction latencies in cycles, with zero memory wait:
  - lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each memory wait cycle adds 1 to the latency.
- Opcode and Funct are sampled only in DECODE and RTEXE. Changes in other states have no effect.

Optional Feature:
- Macro: MIPS_CTRL_PERF_EN.
- Defined:
  - Adds output Instr_count, 32 bits, and output Stall_count, 32 bits. Both reset to 0.
  - Instr_count increments on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB. Illegal-opcode returns are not counted.
  - Stall_count increments on every cycle spent in FETCH, MEMRD or MEMWR with Mem_ready=0.
  - Both counters wrap from 32'hFFFFFFFF to 0.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset and fetch wait: hold Rst_n=0 for 3 cycles, then Mem_ready=0 for 2 cycles, then 1.
  - State=0 throughout; IRWrite=PCEn=0 until the Mem_ready=1 cycle, when both are 1.
  - Next cycle State=1.
- lw: Opcode=6'h23 with Mem_ready=1 always.
  - State sequence 0,1,2,3,4,0.
  - In state 4: RegWrite=1, MemtoReg=1, RegDst=0.
- sw with wait: Opcode=6'h2B and Mem_ready=0 for 3 cycles in MEMWR.
  - MemWrite=1 for 4 consecutive cycles, then State=0.
  - With MIPS_CTRL_PERF_EN defined: Stall_count=3 and Instr_count=1.
- beq: Opcode=6'h04 with Zero=1.
  - PCEn=1 and PCSrc=01 in BRANCH.
  - Repeat with Zero=0: PCEn=0 in BRANCH.
- Illegal opcode: Opcode=6'h3F.
  - Illegal_op=1 for exactly the DECODE cycle, next State=0, Instr_count unchanged.
- Reset mid-operation: assert Rst_n=0 while in MEMRD with Mem_ready=0.
  - State=0 immediately, without waiting for a Clk edge; RegWrite=0.
  - After release, the FSM resumes at FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM driving the shared memory/regfile/ALU datapath.
// Define MIPS_CTRL_PERF_EN to add the Instr_count / Stall_count counters.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               Mem_ready,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               Illegal_op,
  output logic [STATE_W-1:0] State
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0]        Instr_count,
  output logic [31:0]        Stall_count
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXE  = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  state_t state_q, state_d;
  logic   is_sw_q, is_sw_d;
  logic   rdy;
  logic   pc_write;
  logic   pc_write_cond;

  // Funct feeds the external ALU decoder; the FSM itself never looks at it.
  logic unused_funct;
  assign unused_funct = ^Funct;

  // Handshake is ignored while reset is held so FETCH cannot load IR/PC.
  assign rdy = Mem_ready & Rst_n;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    is_sw_d       = is_sw_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSrc         = 2'b00;
    Illegal_op    = 1'b0;
    unique case (state_q)
      FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = rdy;
        pc_write = rdy;
        if (rdy) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        // lw/sw choice is latched here; Opcode is not trusted later.
        is_sw_d = (Opcode == OP_SW);
        unique case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = RTEXE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            Illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_sw_q ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (rdy) state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (rdy) state_d = FETCH;
      end
      RTEXE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        PCSrc         = 2'b01;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        PCSrc    = 2'b10;
        state_d  = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
    PCEn = pc_write | (pc_write_cond & Zero);
  end

  assign State = STATE_W'(state_q);

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        retire;
  logic        stall;

  always_comb begin
    retire = (state_d == FETCH) &&
             (state_q inside {MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB});
    stall  = (state_q inside {FETCH, MEMRD, MEMWR}) && !rdy;
    instr_cnt_d = instr_cnt_q + {31'd0, retire};
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instr_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Instr_count = instr_cnt_q;
  assign Stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed plan steps plus random instruction
// streams checked against a state-sequence model built per instruction.
module tb_mips_multicycle_ctrl;

  logic       Clk, Rst_n;
  logic [5:0] Opcode, Funct;
  logic       Zero, Mem_ready;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       Illegal_op;
  logic [3:0] State;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] Instr_count, Stall_count;
`endif

  int tests = 0;
  int fails = 0;
  int exp_instr = 0;
  int exp_stall = 0;

  typedef struct {
    int st;
    int rdy;
  } item_t;

  logic [15:0] outs;
  assign outs = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal_op};

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .Mem_ready(Mem_ready), .PCEn(PCEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .Illegal_op(Illegal_op), .State(State)
`ifdef MIPS_CTRL_PERF_EN
    , .Instr_count(Instr_count), .Stall_count(Stall_count)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp,
                     input string tag);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
  endfunction

  // Expected control word for a state, straight from the per-state table.
  function automatic logic [15:0] exp_out(input int st, input bit rdy,
                                          input bit z, input logic [5:0] op);
    bit pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
    bit rdst = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
    bit [1:0] sb = 0, ao = 0, ps = 0;
    case (st)
      0: begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1: begin sb = 2'b11; ill = !legal(op); end
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iord = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rdst = 1; end
      8: begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
      9: begin pcw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw | (pcwc & z), iord, mr, mw, irw, rdst, m2r, rw, sa,
            sb, ao, ps, ill};
  endfunction

  task automatic step(input int st, input bit rdy, input bit z,
                      input logic [5:0] op, input bit rst_n,
                      input string tag);
    bit er;
    @(negedge Clk);
    Rst_n     = rst_n;
    Mem_ready = rdy;
    Zero      = z;
    Opcode    = op;
    Funct     = 6'($urandom);
    #1;
    er = rdy & rst_n;
    if (!rst_n) begin
      exp_instr = 0;
      exp_stall = 0;
    end
    chk(32'(State), 32'(st), {tag, "/state"});
    chk(32'(outs), 32'(exp_out(st, er, z, op)), {tag, "/outs"});
`ifdef MIPS_CTRL_PERF_EN
    chk(Instr_count, 32'(exp_instr), {tag, "/instr_cnt"});
    chk(Stall_count, 32'(exp_stall), {tag, "/stall_cnt"});
`endif
    if (rst_n && !er && (st == 0 || st == 3 || st == 5)) exp_stall++;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input bit bz, input string tag);
    item_t q[$];
    for (int i = 0; i < fw; i++) q.push_back('{0, 0});
    q.push_back('{0, 1});
    q.push_back('{1, -1});
    case (op)
      6'h23: begin
        q.push_back('{2, -1});
        for (int i = 0; i < mw; i++) q.push_back('{3, 0});
        q.push_back('{3, 1});
        q.push_back('{4, -1});
      end
      6'h2B: begin
        q.push_back('{2, -1});
        for (int i = 0; i < mw; i++) q.push_back('{5, 0});
        q.push_back('{5, 1});
      end
      6'h00: begin q.push_back('{6, -1}); q.push_back('{7, -1}); end
      6'h08: begin q.push_back('{10, -1}); q.push_back('{11, -1}); end
      6'h04: q.push_back('{8, -1});
      6'h02: q.push_back('{9, -1});
      default: ;
    endcase
    foreach (q[i]) begin
      bit r, z;
      logic [5:0] o;
      r = (q[i].rdy < 0) ? 1'($urandom) : 1'(q[i].rdy);
      z = (q[i].st == 8) ? bz : 1'($urandom);
      o = (q[i].st == 1) ? op : 6'($urandom);
      step(q[i].st, r, z, o, 1'b1, tag);
    end
    if (legal(op)) exp_instr++;
  endtask

  logic [5:0] ops [8];

  initial begin
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
    Rst_n = 1'b1; Mem_ready = 1'b0; Zero = 1'b0;
    Opcode = 6'h00; Funct = 6'h00;
    #2 Rst_n = 1'b0;

    // reset held 3 cycles with Mem_ready high: must stay masked
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 6'h23, 1'b0, "reset");
    run_instr(6'h02, 2, 0, 1'b0, "fetch_wait_j");

    run_instr(6'h23, 0, 0, 1'b0, "lw");

    step(0, 1'b0, 1'b0, 6'h00, 1'b0, "reset2");
    run_instr(6'h2B, 0, 3, 1'b0, "sw_wait");
    @(posedge Clk); #1;
    chk(32'(State), 32'd0, "sw_wait/done");
`ifdef MIPS_CTRL_PERF_EN
    chk(Instr_count, 32'd1, "sw_wait/instr1");
    chk(Stall_count, 32'd3, "sw_wait/stall3");
`endif

    run_instr(6'h04, 0, 0, 1'b1, "beq_taken");
    run_instr(6'h04, 0, 0, 1'b0, "beq_nottaken");
    run_instr(6'h3F, 0, 0, 1'b0, "illegal");
    @(posedge Clk); #1;
    chk(32'(State), 32'd0, "illegal/back_fetch");
`ifdef MIPS_CTRL_PERF_EN
    chk(Instr_count, 32'(exp_instr), "illegal/instr_same");
`endif

    // async reset while stalled in MEMRD
    step(0, 1'b1, 1'b0, 6'h00, 1'b1, "midrst/fetch");
    step(1, 1'b0, 1'b0, 6'h23, 1'b1, "midrst/decode");
    step(2, 1'b0, 1'b0, 6'h2B, 1'b1, "midrst/memadr");
    step(3, 1'b0, 1'b0, 6'h2B, 1'b1, "midrst/memrd");
    #2 Rst_n = 1'b0;
    #1;
    exp_instr = 0;
    exp_stall = 0;
    chk(32'(State), 32'd0, "midrst/async_state");
    chk(32'(RegWrite), 32'd0, "midrst/regwrite");
    chk(32'(outs), 32'(exp_out(0, 1'b0, Zero, Opcode)), "midrst/outs");
`ifdef MIPS_CTRL_PERF_EN
    chk(Instr_count, 32'd0, "midrst/instr0");
    chk(Stall_count, 32'd0, "midrst/stall0");
`endif
    step(0, 1'b1, 1'b0, 6'h23, 1'b0, "midrst/held");
    run_instr(6'h00, 1, 0, 1'b0, "midrst/resume_r");

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(7)];
      run_instr(op, $urandom_range(2), $urandom_range(2),
                1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
